// File: rtl/wqe_dispatch_scheduler.sv
// Work-queue dispatch: round-robin pop of SQ/RQ WQEs, malformed-entry drop,
// single-descriptor DMA issue stage and an in-flight credit counter.
module wqe_dispatch_scheduler #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               sqEmpty,
    input  logic [111:0]       sqData,
    output logic               sqPop,
    input  logic               rqEmpty,
    input  logic [111:0]       rqData,
    output logic               rqPop,
    output logic               dmaValid,
    input  logic               dmaReady,
    output logic [111:0]       dmaDesc,
    output logic               dmaQueue,
    input  logic               cplValid,
    output logic [CNT_W-1:0]   outstanding,
    output logic [CNT_W-1:0]   dropCount,
    output logic               cplErr,
    output logic               busy,
    output logic [0:0]         dbgState
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    localparam logic [CNT_W-1:0] OUT_LIMIT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [0:0]   state;
    logic         rrPtr;
    logic         sqAvail;
    logic         rqAvail;
    logic         startIssue;
    logic         selRq;
    logic [111:0] headWord;
    logic [2:0]   headDataNum;
    logic         headMalformed;
    logic         issueAccept;

    assign sqAvail = ~sqEmpty;
    assign rqAvail = ~rqEmpty;

    // Pops are combinational with the start decision; reset gates them so a
    // FIFO is never drained while the scheduler is held in reset.
    assign startIssue = ~reset & (state == IDLE) & enable
                      & (outstanding < OUT_LIMIT) & (sqAvail | rqAvail);
    assign selRq      = (sqAvail & rqAvail) ? rrPtr : ~sqAvail;
    assign headWord   = selRq ? rqData : sqData;

    assign headDataNum   = headWord[106:104];
    assign headMalformed = (headDataNum == 3'd0) || (headDataNum > 3'd4);

    assign sqPop = startIssue & ~selRq;
    assign rqPop = startIssue & selRq;

    // Handshake: dmaValid rises with a registered descriptor and stays high with
    // dmaDesc/dmaQueue frozen until the cycle dmaValid & dmaReady is seen; that
    // cycle is the transfer, and dmaValid is low on the following cycle.
    assign dmaValid    = (state == ISSUE);
    assign issueAccept = dmaValid & dmaReady;

    assign busy     = (state != IDLE) | (outstanding != '0);
    assign dbgState = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rrPtr    <= 1'b0;
            dmaDesc  <= '0;
            dmaQueue <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (startIssue) begin
                        if (headMalformed) begin
                            rrPtr <= ~selRq;
                        end else begin
                            dmaDesc  <= headWord;
                            dmaQueue <= selRq;
                            state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issueAccept) begin
                        rrPtr <= ~dmaQueue;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // An accept and a completion in the same cycle cancel; a lone completion
    // with nothing in flight is recorded as a sticky protocol error.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
            cplErr      <= 1'b0;
        end else begin
            case ({issueAccept, cplValid})
                2'b10: outstanding <= outstanding + 1'b1;
                2'b01: begin
                    if (outstanding == '0) begin
                        cplErr <= 1'b1;
                    end else begin
                        outstanding <= outstanding - 1'b1;
                    end
                end
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dropCount <= '0;
        end else if (startIssue && headMalformed && (dropCount != CNT_MAX)) begin
            dropCount <= dropCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_wqe_dispatch_scheduler.sv
// Bench for wqe_dispatch_scheduler: queue-based FIFO/credit model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_wqe_dispatch_scheduler;

    localparam int MAX_OUT = 4;
    localparam int CW      = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           enable = 1'b0;
    logic           sqEmpty = 1'b1;
    logic [111:0]   sqData = '0;
    logic           sqPop;
    logic           rqEmpty = 1'b1;
    logic [111:0]   rqData = '0;
    logic           rqPop;
    logic           dmaValid;
    logic           dmaReady = 1'b0;
    logic [111:0]   dmaDesc;
    logic           dmaQueue;
    logic           cplValid = 1'b0;
    logic [CW-1:0]  outstanding;
    logic [CW-1:0]  dropCount;
    logic           cplErr;
    logic           busy;
    logic [0:0]     dbgState;

    wqe_dispatch_scheduler #(.MAX_OUTSTANDING(MAX_OUT), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .sqEmpty(sqEmpty), .sqData(sqData), .sqPop(sqPop),
        .rqEmpty(rqEmpty), .rqData(rqData), .rqPop(rqPop),
        .dmaValid(dmaValid), .dmaReady(dmaReady), .dmaDesc(dmaDesc),
        .dmaQueue(dmaQueue), .cplValid(cplValid), .outstanding(outstanding),
        .dropCount(dropCount), .cplErr(cplErr), .busy(busy), .dbgState(dbgState)
    );

    always #5 clock = ~clock;

    // Bench-side FIFOs and the reference model
    logic [111:0] sqQ[$];
    logic [111:0] rqQ[$];
    logic [112:0] expQ[$];      // {queue id, descriptor} awaiting acceptance
    logic         accLog[$];
    logic [111:0] accDesc[$];
    int           mOut;
    int           mDrops;
    bit           mRr;
    bit           mCplErr;
    bit           doPopSq;
    bit           doPopRq;
    int           nChecks = 0;
    int           nErrors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [111:0] make_wqe(input logic [2:0] n);
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        r[106:104] = n;
        return r[111:0];
    endfunction

    function automatic logic [2:0] good_num();
        return 3'($urandom_range(1, 4));
    endfunction

    task automatic refresh_fifo();
        sqEmpty = (sqQ.size() == 0);
        rqEmpty = (rqQ.size() == 0);
        sqData  = sqEmpty ? '0 : sqQ[0];
        rqData  = rqEmpty ? '0 : rqQ[0];
    endtask

    task automatic model_reset();
        expQ.delete();
        mOut = 0; mDrops = 0; mRr = 1'b0; mCplErr = 1'b0;
        doPopSq = 1'b0; doPopRq = 1'b0;
    endtask

    // Compare every output against the model, then advance the model by one edge.
    task automatic check_cycle();
        bit pend, sqNe, rqNe, useRq, acc, expSq, expRq;
        logic [111:0] word;
        logic [112:0] e;
        pend = (expQ.size() != 0);
        sqNe = (sqQ.size() != 0);
        rqNe = (rqQ.size() != 0);
        chk("dmaValid", dmaValid, pend);
        chk("dbgState", dbgState, pend);
        if (pend) begin
            chk("dmaDesc", dmaDesc, expQ[0][111:0]);
            chk("dmaQueue", dmaQueue, expQ[0][112]);
        end
        chk("outstanding", outstanding, mOut);
        chk("dropCount", dropCount, mDrops);
        chk("cplErr", cplErr, mCplErr);
        chk("busy", busy, pend || (mOut != 0));
        expSq = 1'b0; expRq = 1'b0; useRq = 1'b0; word = '0;
        if (!pend && enable && (mOut < MAX_OUT) && (sqNe || rqNe)) begin
            useRq = (sqNe && rqNe) ? mRr : !sqNe;
            word  = useRq ? rqQ[0] : sqQ[0];
            expSq = !useRq;
            expRq = useRq;
        end
        chk("sqPop", sqPop, expSq);
        chk("rqPop", rqPop, expRq);
        doPopSq = expSq;
        doPopRq = expRq;
        acc = pend && dmaReady;
        if (expSq || expRq) begin
            if (word[106:104] == 3'd0 || word[106:104] > 3'd4) begin
                if (mDrops < 15) mDrops++;
                mRr = !useRq;
            end else begin
                expQ.push_back({useRq, word});
            end
        end
        if (acc) begin
            e = expQ.pop_front();
            mRr = !e[112];
            accLog.push_back(e[112]);
            accDesc.push_back(e[111:0]);
        end
        if (acc && !cplValid) mOut++;
        else if (cplValid && !acc) begin
            if (mOut == 0) mCplErr = 1'b1;
            else mOut--;
        end
    endtask

    task automatic step();
        @(negedge clock);
        check_cycle();
        @(posedge clock);
        #1;
        if (doPopSq) void'(sqQ.pop_front());
        if (doPopRq) void'(rqQ.pop_front());
        doPopSq = 1'b0;
        doPopRq = 1'b0;
        refresh_fifo();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input bit clearQ);
        reset = 1'b1;
        cplValid = 1'b0;
        #1;
        chk("rst_dmaValid", dmaValid, 1'b0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_dropCount", dropCount, 0);
        chk("rst_cplErr", cplErr, 1'b0);
        chk("rst_pops", {sqPop, rqPop}, 2'b00);
        chk("rst_state", dbgState, 1'b0);
        model_reset();
        if (clearQ) begin
            sqQ.delete();
            rqQ.delete();
        end
        accLog.delete();
        accDesc.delete();
        refresh_fifo();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [5:0]   altPat;
        logic [111:0] held;
        logic [111:0] want[$];
        logic [111:0] w;

        do_reset(1'b1);

        // Alternation between SQ and RQ with completions returning each cycle
        enable = 1'b1; dmaReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w = make_wqe(good_num()); sqQ.push_back(w);
        end
        for (int i = 0; i < 3; i++) begin
            w = make_wqe(good_num()); rqQ.push_back(w);
        end
        for (int i = 0; i < 3; i++) begin
            want.push_back(sqQ[i]);
            want.push_back(rqQ[i]);
        end
        refresh_fifo();
        for (int i = 0; i < 20; i++) begin
            cplValid = (mOut != 0);
            step();
        end
        cplValid = 1'b0;
        altPat = 6'b101010;
        chk("alt_count", accLog.size(), 6);
        for (int i = 0; i < 6 && i < accLog.size(); i++) begin
            chk("alt_queue", accLog[i], altPat[i]);
            chk("alt_desc", accDesc[i], want[i]);
        end

        // Credit limit: six SQ entries, no completions
        do_reset(1'b1);
        enable = 1'b1; dmaReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            w = make_wqe(good_num()); sqQ.push_back(w);
        end
        refresh_fifo();
        run(30);
        chk("credit_accepts", accLog.size(), 4);
        chk("credit_outstanding", outstanding, 4);
        chk("credit_sqPop", sqPop, 1'b0);
        cplValid = 1'b1;
        step();
        cplValid = 1'b0;
        run(10);
        chk("credit_resume", accLog.size(), 5);

        // Backpressure holds the descriptor
        do_reset(1'b1);
        enable = 1'b1; dmaReady = 1'b0;
        held = make_wqe(good_num());
        sqQ.push_back(held);
        w = make_wqe(good_num()); sqQ.push_back(w);
        refresh_fifo();
        run(12);
        chk("bp_valid", dmaValid, 1'b1);
        chk("bp_desc", dmaDesc, held);
        dmaReady = 1'b1;
        step();
        chk("bp_outstanding", outstanding, 1);
        dmaReady = 1'b0;
        run(4);

        // Malformed entries are dropped
        do_reset(1'b1);
        enable = 1'b1; dmaReady = 1'b1;
        w = make_wqe(3'd0); rqQ.push_back(w);
        w = make_wqe(3'd5); rqQ.push_back(w);
        w = make_wqe(3'd4); rqQ.push_back(w);
        refresh_fifo();
        run(10);
        chk("drop_count", dropCount, 2);
        chk("drop_issued", accLog.size(), 1);

        // Accept + completion together, then completion underflow
        do_reset(1'b1);
        enable = 1'b1; dmaReady = 1'b1;
        for (int i = 0; i < 2; i++) begin
            w = make_wqe(good_num()); sqQ.push_back(w);
        end
        refresh_fifo();
        run(8);
        chk("edge_out2", outstanding, 2);
        dmaReady = 1'b0;
        w = make_wqe(good_num()); sqQ.push_back(w);
        refresh_fifo();
        run(3);
        dmaReady = 1'b1; cplValid = 1'b1;
        step();
        cplValid = 1'b0;
        chk("edge_acc_cpl", outstanding, 2);
        cplValid = 1'b1;
        run(2);
        chk("edge_drained", outstanding, 0);
        step();
        cplValid = 1'b0;
        chk("edge_cplErr", cplErr, 1'b1);
        chk("edge_out0", outstanding, 0);
        run(2);

        // Reset during ISSUE, then disabled dispatch
        do_reset(1'b1);
        enable = 1'b1; dmaReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w = make_wqe(good_num()); sqQ.push_back(w);
        end
        refresh_fifo();
        run(2);
        dmaReady = 1'b0;
        run(3);
        chk("mid_valid", dmaValid, 1'b1);
        do_reset(1'b0);
        enable = 1'b0;
        w = make_wqe(good_num()); rqQ.push_back(w);
        refresh_fifo();
        run(5);
        chk("dis_busy", busy, 1'b0);
        chk("dis_pops", {sqPop, rqPop}, 2'b00);

        // Random traffic
        do_reset(1'b1);
        for (int i = 0; i < 1500; i++) begin
            if (sqQ.size() < 8 && $urandom_range(0, 2) == 0) begin
                w = make_wqe(($urandom_range(0, 5) == 0) ? 3'($urandom_range(5, 7)) : good_num());
                sqQ.push_back(w);
            end
            if (rqQ.size() < 8 && $urandom_range(0, 2) == 0) begin
                w = make_wqe(($urandom_range(0, 9) == 0) ? 3'd0 : good_num());
                rqQ.push_back(w);
            end
            refresh_fifo();
            enable   = ($urandom_range(0, 7) != 0);
            dmaReady = ($urandom_range(0, 3) != 0);
            cplValid = ($urandom_range(0, 2) == 0) && ((mOut != 0) || ($urandom_range(0, 49) == 0));
            step();
        end
        cplValid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/wqe_dispatch_scheduler.md
Name: wqe_dispatch_scheduler

Overview:
Sits between the send and receive work-queue FIFOs and the DMA descriptor engine. It arbitrates round-robin between SQ and RQ and pops one 112-bit work-queue entry (WQE) at a time. It validates the entry, presents it to the DMA engine over a valid/ready handshake, and limits the number of WQEs in flight using a credit counter returned by DMA completions.

Parameters:
MAX_OUTSTANDING, 4, maximum WQEs issued to DMA but not yet completed (1..15)
CNT_W, 4, width of the outstanding counter and the drop counter

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-high reset
enable  in  1  dispatch enable; when low, no new arbitration starts
sqEmpty  in  1  SQ FIFO empty
sqData  in  112  SQ FIFO head word (first-word-fall-through)
sqPop  out  1  SQ FIFO pop strobe
rqEmpty  in  1  RQ FIFO empty
rqData  in  112  RQ FIFO head word (first-word-fall-through)
rqPop  out  1  RQ FIFO pop strobe
dmaValid  out  1  descriptor valid
dmaReady  in  1  DMA engine accepts descriptor
dmaDesc  out  112  registered WQE
dmaQueue  out  1  source of dmaDesc: 0 = SQ, 1 = RQ
cplValid  in  1  one-cycle completion pulse from DMA
outstanding  out  CNT_W  WQEs currently in flight
dropCount  out  CNT_W  saturating count of discarded malformed WQEs
cplErr  out  1  sticky: a completion arrived with outstanding == 0
busy  out  1  high in any state other than IDLE, or when outstanding != 0

Behaviour:
- WQE field map, MSB first: opcode[111:107], dataNum[106:104], dataLen0..3 in [103:72] (8 bits each), TID[71:64], descTableAddr[63:0].
- Reset values: all outputs 0, rrPtr = 0 (SQ preferred first), FSM = IDLE.
- FIFO head data is valid in the same cycle the FIFO's empty flag is low. A pop takes effect at the next clock edge.
- FSM states: IDLE, ISSUE.
- IDLE, start condition: enable & (outstanding < MAX_OUTSTANDING) & (~sqEmpty | ~rqEmpty).
- IDLE, queue selection: if both queues are non-empty, select the queue given by rrPtr; otherwise select the single non-empty queue.
- IDLE, on start (same cycle, combinational): assert the selected pop for exactly that cycle.
- IDLE, on start (next edge): register the selected head word into dmaDesc and the queue id into dmaQueue.
- Drop check: a WQE with dataNum == 0 or dataNum > 4 is malformed. It is popped and discarded, dropCount increments (saturating at all-ones), and the FSM stays in IDLE. rrPtr still toggles to the other queue.
- Valid WQE: the FSM moves to ISSUE.
- ISSUE: dmaValid = 1, and dmaDesc and dmaQueue are held stable until accepted.
- On dmaValid & dmaReady: outstanding increments, rrPtr is set to ~dmaQueue, the FSM returns to IDLE, and dmaValid drops on the next cycle.
- Issue rate: one WQE can be issued every 2 cycles at best.
- enable going low during ISSUE does not withdraw the descriptor; the WQE in ISSUE completes normally.
- cplValid decrements outstanding.
- Simultaneous issue accept and cplValid in the same cycle: outstanding is unchanged.
- cplValid with outstanding == 0: counter stays at 0 and cplErr is set until reset.
- A pop is never asserted on an empty FIFO. sqPop and rqPop are never asserted in the same cycle.
- When outstanding == MAX_OUTSTANDING, the FSM stays in IDLE with no pops. It resumes the cycle after a completion brings outstanding below the limit.
- Reset asserted mid-operation: the FSM returns to IDLE and outstanding clears; an in-flight dmaValid drops immediately (asynchronously).

Test Plan:
1. Alternation: push 3 valid WQEs to SQ and 3 to RQ, dmaReady = 1, cplValid each cycle -> dmaQueue sequence is 0,1,0,1,0,1 and each WQE appears on dmaDesc bit-exact.
2. Credit limit: MAX_OUTSTANDING = 4, 6 SQ WQEs, no completions -> exactly 4 dmaValid accepts, outstanding = 4, sqPop stays low. After one cplValid pulse, the 5th WQE issues.
3. Backpressure: dmaReady held low for 10 cycles -> dmaValid stays high, dmaDesc is unchanged, no further pops. With dmaReady = 1, the WQE is accepted in one cycle and outstanding = 1.
4. Malformed WQEs: RQ WQEs with dataNum = 0 and dataNum = 5 -> both popped, no dmaValid, dropCount = 2. A following valid WQE issues normally.
5. Counter edge cases: cplValid in the same cycle as an issue accept with outstanding = 2 -> outstanding stays 2. cplValid with outstanding = 0 -> cplErr = 1, outstanding = 0.
6. Reset and enable: assert reset during ISSUE -> dmaValid = 0 immediately, outstanding = 0, FSM in IDLE. With enable = 0 and FIFOs non-empty -> no pops, busy = 0.
